pc_redirect_ctrl: RTL and testbench

- Owns the fetch PC register and sequences every PC update in the 5-stage RISC-V pipeline.
- Arbitrates between four next-PC sources: sequential, decode-stage jump, execute-stage taken branch, and trap.
- Drives the stall and flush controls for the IF/ID and ID/EX pipeline registers.
- Buffers a redirect that arrives while instruction memory is busy, and applies it once memory is ready.

---
 rtl/pc_redirect_ctrl_if.sv | 31 +++
 rtl/pc_redirect_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Handshake/bus bundle between the hazard/commit logic and the fetch PC controller.
// The master drives the redirect/stall requests and the slave (the controller) drives the fetch controls.
interface pc_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              trapReq;
    logic              branchTakenE;
    logic [31:0]       branchTargetE;
    logic              jumpD;
    logic [31:0]       jumpTargetD;
    logic              stallReq;
    logic              imemReady;
    logic [31:0]       pcF;
    logic              stallF;
    logic              stallD;
    logic              flushD;
    logic              flushE;
    logic              misalign;
    logic              redirect;
    logic [CNT_W-1:0]  redirCnt;

    modport master (
        output trapReq, branchTakenE, branchTargetE, jumpD, jumpTargetD, stallReq, imemReady,
        input  pcF, stallF, stallD, flushD, flushE, misalign, redirect, redirCnt
    );

    modport slave (
        input  trapReq, branchTakenE, branchTargetE, jumpD, jumpTargetD, stallReq, imemReady,
        output pcF, stallF, stallD, flushD, flushE, misalign, redirect, redirCnt
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: arbitrates trap > branch > jump > sequential and drives pipeline stall/flush.
// Redirects land on pcF one edge after they are seen; a redirect during imem backpressure is parked in PEND.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_redirect_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_nxt;
    logic [31:0]       r_pend_pc;
    logic [31:0]       w_pend_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_redirect;
    logic              w_apply;

    logic              w_hi_evt;
    logic              w_evt;
    logic [31:0]       w_raw_tgt;
    logic [31:0]       w_tgt;
    logic              w_misalign;

    logic              w_stall_f;
    logic              w_stall_d;
    logic              w_flush_d;
    logic              w_flush_e;

    // Jumps only count in RUN; in PEND decode is already being flushed.
    always_comb begin
        w_hi_evt  = bus.trapReq | bus.branchTakenE;
        w_raw_tgt = bus.trapReq      ? TRAP_VEC          :
                    bus.branchTakenE ? bus.branchTargetE :
                                       bus.jumpTargetD;
        w_evt     = 1'b0;
        if (r_state == RUN) begin
            w_evt = w_hi_evt | bus.jumpD;
        end else if (r_state == PEND) begin
            w_evt = w_hi_evt;
        end
        w_misalign = reset & w_evt & ~bus.trapReq & (w_raw_tgt[1:0] != 2'b00);
        w_tgt      = w_misalign ? TRAP_VEC : w_raw_tgt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_pc;
        w_apply     = 1'b0;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;

        case (r_state)
            BOOT: begin
                w_stall_f   = 1'b1;
                w_flush_d   = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_evt) begin
                    // A redirect overrides any load-use stall in the same cycle.
                    w_flush_d = 1'b1;
                    w_flush_e = w_hi_evt;
                    w_stall_f = ~bus.imemReady;
                    if (bus.imemReady) begin
                        w_pc_nxt = w_tgt;
                        w_apply  = 1'b1;
                    end else begin
                        w_pend_nxt  = w_tgt;
                        w_state_nxt = PEND;
                    end
                end else begin
                    w_stall_f = bus.stallReq | ~bus.imemReady;
                    w_stall_d = bus.stallReq;
                    w_flush_e = bus.stallReq;
                    if (!(bus.stallReq | ~bus.imemReady)) begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            PEND: begin
                w_stall_f = 1'b1;
                w_flush_d = 1'b1;
                w_flush_e = w_hi_evt;
                if (w_evt) begin
                    w_pend_nxt = w_tgt;
                end
                if (bus.imemReady) begin
                    w_pc_nxt    = w_evt ? w_tgt : r_pend_pc;
                    w_apply     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase

        if (!reset) begin
            w_stall_f = 1'b0;
            w_stall_d = 1'b0;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'h0;
            r_cnt      <= '0;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_nxt;
            r_redirect <= w_apply;
            if (w_apply && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pcF      = r_pc;
    assign bus.stallF   = w_stall_f;
    assign bus.stallD   = w_stall_d;
    assign bus.flushD   = w_flush_d;
    assign bus.flushE   = w_flush_e;
    assign bus.misalign = w_misalign;
    assign bus.redirect = r_redirect;
    assign bus.redirCnt = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; a narrow counter makes saturation reachable.
module tb_pc_redirect_ctrl;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_redirect_ctrl_if #(.CNT_W(CW)) bus ();

    pc_redirect_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0004),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        redir;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic trap, input logic br, input logic [31:0] bt,
                         input logic jmp, input logic [31:0] jt, input logic stall, input logic rdy);
        bus.trapReq       = trap;
        bus.branchTakenE  = br;
        bus.branchTargetE = bt;
        bus.jumpD         = jmp;
        bus.jumpTargetD   = jt;
        bus.stallReq      = stall;
        bus.imemReady     = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // Combinational outputs, sampled mid-cycle.
    task automatic comb(input string tag, input logic sf, input logic sd,
                        input logic fd, input logic fe, input logic mis);
        #1;
        chk({tag, ".stallF"},   32'(bus.stallF),   32'(sf));
        chk({tag, ".stallD"},   32'(bus.stallD),   32'(sd));
        chk({tag, ".flushD"},   32'(bus.flushD),   32'(fd));
        chk({tag, ".flushE"},   32'(bus.flushE),   32'(fe));
        chk({tag, ".misalign"}, 32'(bus.misalign), 32'(mis));
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic redir);
        exp_t e;
        if (redir && ecnt < (1 << CW) - 1) ecnt++;
        e.tag   = tag;
        e.pc    = pc;
        e.redir = redir;
        e.cnt   = 32'(ecnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pcF"},      bus.pcF,            e.pc);
        chk({e.tag, ".redirect"}, 32'(bus.redirect),  32'(e.redir));
        chk({e.tag, ".redirCnt"}, 32'(bus.redirCnt),  e.cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: a misaligned branch must not raise misalign.
        drive(1'b0, 1'b1, 32'h101, 1'b0, 32'h0, 1'b0, 1'b1);
        comb("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst.pcF", bus.pcF, 32'h0);
        chk("rst.redirect", 32'(bus.redirect), 32'h0);
        chk("rst.redirCnt", 32'(bus.redirCnt), 32'h0);

        @(posedge clk); #1;
        idle();
        reset = 1'b1;
        comb("boot", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("boot", 32'h0, 1'b0);
        for (int a = 4; a <= 32; a += 4) step("seq", 32'(a), 1'b0);

        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        comb("br", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("br", 32'h100, 1'b1);
        idle();
        step("br_after", 32'h104, 1'b0);

        drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b1);
        comb("brjs", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("brjs", 32'h100, 1'b1);
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b1);
        comb("trap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("trap", 32'h4, 1'b1);

        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1);
        comb("jmp", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("jmp", 32'h200, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b1);
        comb("jmis", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("jmis", 32'h4, 1'b1);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        comb("ldst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("ldst", 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        comb("nrdy", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nrdy", 32'h4, 1'b0);

        // Branch while imem busy, ready three cycles later.
        drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        comb("pend0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("pend0", 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        comb("pend1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("pend1", 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h302, 1'b0, 1'b0);
        comb("pendj", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("pendj", 32'h4, 1'b0);
        idle();
        comb("pend3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("pend3", 32'h200, 1'b1);
        step("pend_after", 32'h204, 1'b0);

        // Trap overrides the parked branch target.
        drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        step("povr0", 32'h204, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        comb("povr1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("povr1", 32'h204, 1'b0);
        idle();
        step("povr2", 32'h4, 1'b1);

        // Override arriving in the same cycle imem becomes ready.
        drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        step("psame0", 32'h4, 1'b0);
        drive(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b1);
        step("psame1", 32'h500, 1'b1);

        drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        step("pmis0", 32'h500, 1'b0);
        drive(1'b0, 1'b1, 32'h301, 1'b0, 32'h0, 1'b0, 1'b1);
        comb("pmis1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step("pmis1", 32'h4, 1'b1);

        // Sequential wrap at the top of the address space.
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 1'b1);
        step("wrap0", 32'hFFFF_FFF8, 1'b1);
        idle();
        step("wrap1", 32'hFFFF_FFFC, 1'b0);
        step("wrap2", 32'h0, 1'b0);
        step("wrap3", 32'h4, 1'b0);

        // Reset while a redirect is parked.
        drive(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
        step("rpend0", 32'h4, 1'b0);
        reset = 1'b0;
        idle();
        ecnt = 0;
        comb("rpend", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rpend.pcF", bus.pcF, 32'h0);
        chk("rpend.redirCnt", 32'(bus.redirCnt), 32'h0);
        step("rhold", 32'h0, 1'b0);
        reset = 1'b1;
        comb("boot2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("boot2", 32'h0, 1'b0);
        step("boot2_seq", 32'h4, 1'b0);

        // Counter saturation.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step("sat", 32'h40, 1'b1);
        idle();
        step("sat_end", 32'h44, 1'b0);
        chk("sat.value", 32'(bus.redirCnt), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
